// File: rtl/axi_slave_ram.sv
// AXI4 slave RAM: word-addressed memory with independent read/write FSMs and INCR/FIXED bursts.
// Optional macro AXI_SLAVE_RAM_WAIT_EN adds C_WAIT_CYCLES of first-beat latency on both channels.
module axi_slave_ram #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 28,
  parameter int C_MEM_WORDS      = 2048,
  parameter int C_WAIT_CYCLES    = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [C_OFFSET_WIDTH-1:0]     AWADDR,
  input  logic [7:0]                    AWLEN,
  input  logic [2:0]                    AWSIZE,
  input  logic [1:0]                    AWBURST,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                          WLAST,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [C_OFFSET_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                    ARLEN,
  input  logic [2:0]                    ARSIZE,
  input  logic [1:0]                    ARBURST,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RLAST,
  output logic                          RVALID,
  input  logic                          RREADY
);
  localparam int IDX_W = $clog2(C_MEM_WORDS);
  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || (burst == BURST_WRAP);
  endfunction

  function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] idx, input logic fixed);
    return fixed ? idx : idx + IDX_W'(1'b1);
  endfunction

  logic [C_AXI_DATA_WIDTH-1:0] mem_r [C_MEM_WORDS];

  w_state_t             w_state_r, w_state_nx;
  logic [IDX_W-1:0]     w_idx_r, w_idx_nx;
  logic [7:0]           w_len_r, w_len_nx, w_cnt_r, w_cnt_nx;
  logic                 w_fixed_r, w_fixed_nx, w_err_r, w_err_nx, w_lerr_r, w_lerr_nx;
  logic                 awready_r, awready_nx, wready_r, wready_nx, bvalid_r, bvalid_nx;
  logic [1:0]           bresp_r, bresp_nx;
  logic                 mem_we_s;

  r_state_t             r_state_r, r_state_nx;
  logic [IDX_W-1:0]     r_idx_r, r_idx_nx, rd_addr_s;
  logic [7:0]           r_len_r, r_len_nx, r_cnt_r, r_cnt_nx;
  logic                 r_fixed_r, r_fixed_nx, r_err_r, r_err_nx;
  logic                 arready_r, arready_nx, rvalid_r, rvalid_nx, rlast_r, rlast_nx;
  logic [1:0]           rresp_r, rresp_nx;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_r;
  logic                 rd_load_s;
`ifdef AXI_SLAVE_RAM_WAIT_EN
  logic [7:0]           w_wait_r, w_wait_nx, r_wait_r, r_wait_nx;
`endif

  logic unused_s;
  assign unused_s = ^{AWADDR[C_OFFSET_WIDTH-1:IDX_W+2], AWADDR[1:0],
                      ARADDR[C_OFFSET_WIDTH-1:IDX_W+2], ARADDR[1:0], (C_WAIT_CYCLES != 32'sd0)};

  assign AWREADY = awready_r;
  assign WREADY  = wready_r;
  assign BVALID  = bvalid_r;
  assign BRESP   = bresp_r;
  assign ARREADY = arready_r;
  assign RVALID  = rvalid_r;
  assign RLAST   = rlast_r;
  assign RRESP   = rresp_r;
  assign RDATA   = rdata_r;

  // Write channel next state and next registered-output values
  always_comb begin
    w_state_nx = w_state_r;
    w_idx_nx   = w_idx_r;
    w_len_nx   = w_len_r;
    w_cnt_nx   = w_cnt_r;
    w_fixed_nx = w_fixed_r;
    w_err_nx   = w_err_r;
    w_lerr_nx  = w_lerr_r;
    awready_nx = 1'b0;
    wready_nx  = 1'b0;
    bvalid_nx  = bvalid_r;
    bresp_nx   = bresp_r;
    mem_we_s   = 1'b0;
`ifdef AXI_SLAVE_RAM_WAIT_EN
    w_wait_nx  = w_wait_r;
`endif
    case (w_state_r)
      W_IDLE: begin
        awready_nx = 1'b1;
        if (AWVALID && awready_r) begin
          w_state_nx = W_DATA;
          w_idx_nx   = AWADDR[IDX_W+1:2];
          w_len_nx   = AWLEN;
          w_cnt_nx   = 8'd0;
          w_fixed_nx = (AWBURST == BURST_FIXED);
          w_err_nx   = burst_err(AWSIZE, AWBURST);
          w_lerr_nx  = 1'b0;
          awready_nx = 1'b0;
`ifdef AXI_SLAVE_RAM_WAIT_EN
          w_wait_nx  = 8'(C_WAIT_CYCLES);
          wready_nx  = (C_WAIT_CYCLES == 32'sd0);
`else
          wready_nx  = 1'b1;
`endif
        end else begin
          w_state_nx = W_IDLE;
        end
      end
      W_DATA: begin
        wready_nx = 1'b1;
`ifdef AXI_SLAVE_RAM_WAIT_EN
        if (w_wait_r != 8'd0) begin
          w_wait_nx = w_wait_r - 8'd1;
          wready_nx = (w_wait_r == 8'd1);
        end else begin
          w_wait_nx = 8'd0;
        end
`endif
        if (WVALID && wready_r) begin
          mem_we_s = !w_err_r;
          if (w_cnt_r == w_len_r) begin
            w_state_nx = W_RESP;
            wready_nx  = 1'b0;
            bvalid_nx  = 1'b1;
            bresp_nx   = (w_err_r || w_lerr_r || !WLAST) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            w_cnt_nx  = w_cnt_r + 8'd1;
            w_idx_nx  = step_idx(w_idx_r, w_fixed_r);
            w_lerr_nx = w_lerr_r || WLAST;
          end
        end else begin
          mem_we_s = 1'b0;
        end
      end
      W_RESP: begin
        if (BREADY && bvalid_r) begin
          w_state_nx = W_IDLE;
          bvalid_nx  = 1'b0;
          bresp_nx   = RESP_OKAY;
          awready_nx = 1'b1;
        end else begin
          bvalid_nx  = 1'b1;
        end
      end
      default: begin
        w_state_nx = W_IDLE;
      end
    endcase
  end

  // Write channel state and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      w_state_r <= W_IDLE;
      w_idx_r   <= {IDX_W{1'b0}};
      w_len_r   <= 8'd0;
      w_cnt_r   <= 8'd0;
      w_fixed_r <= 1'b0;
      w_err_r   <= 1'b0;
      w_lerr_r  <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
`ifdef AXI_SLAVE_RAM_WAIT_EN
      w_wait_r  <= 8'd0;
`endif
    end else begin
      w_state_r <= w_state_nx;
      w_idx_r   <= w_idx_nx;
      w_len_r   <= w_len_nx;
      w_cnt_r   <= w_cnt_nx;
      w_fixed_r <= w_fixed_nx;
      w_err_r   <= w_err_nx;
      w_lerr_r  <= w_lerr_nx;
      awready_r <= awready_nx;
      wready_r  <= wready_nx;
      bvalid_r  <= bvalid_nx;
      bresp_r   <= bresp_nx;
`ifdef AXI_SLAVE_RAM_WAIT_EN
      w_wait_r  <= w_wait_nx;
`endif
    end
  end

  // RAM write port with byte enables; contents survive reset
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) begin
          mem_r[w_idx_r][8*b +: 8] <= WDATA[8*b +: 8];
        end
      end
    end
  end

  // Read channel next state, RAM read request and next registered-output values
  always_comb begin
    r_state_nx = r_state_r;
    r_idx_nx   = r_idx_r;
    r_len_nx   = r_len_r;
    r_cnt_nx   = r_cnt_r;
    r_fixed_nx = r_fixed_r;
    r_err_nx   = r_err_r;
    arready_nx = 1'b0;
    rvalid_nx  = rvalid_r;
    rlast_nx   = rlast_r;
    rresp_nx   = rresp_r;
    rd_load_s  = 1'b0;
    rd_addr_s  = r_idx_r;
`ifdef AXI_SLAVE_RAM_WAIT_EN
    r_wait_nx  = r_wait_r;
`endif
    case (r_state_r)
      R_IDLE: begin
        arready_nx = 1'b1;
        if (ARVALID && arready_r) begin
          r_state_nx = R_ADDR;
          r_idx_nx   = ARADDR[IDX_W+1:2];
          r_len_nx   = ARLEN;
          r_cnt_nx   = 8'd0;
          r_fixed_nx = (ARBURST == BURST_FIXED);
          r_err_nx   = burst_err(ARSIZE, ARBURST);
          arready_nx = 1'b0;
`ifdef AXI_SLAVE_RAM_WAIT_EN
          r_wait_nx  = 8'(C_WAIT_CYCLES);
`endif
        end else begin
          r_state_nx = R_IDLE;
        end
      end
      R_ADDR: begin
`ifdef AXI_SLAVE_RAM_WAIT_EN
        if (r_wait_r != 8'd0) begin
          r_wait_nx = r_wait_r - 8'd1;
        end else begin
          r_state_nx = R_DATA;
          rd_load_s  = 1'b1;
          rvalid_nx  = 1'b1;
          rlast_nx   = (r_len_r == 8'd0);
          rresp_nx   = r_err_r ? RESP_SLVERR : RESP_OKAY;
        end
`else
        r_state_nx = R_DATA;
        rd_load_s  = 1'b1;
        rvalid_nx  = 1'b1;
        rlast_nx   = (r_len_r == 8'd0);
        rresp_nx   = r_err_r ? RESP_SLVERR : RESP_OKAY;
`endif
      end
      R_DATA: begin
        if (RREADY && rvalid_r) begin
          if (rlast_r) begin
            r_state_nx = R_IDLE;
            rvalid_nx  = 1'b0;
            rlast_nx   = 1'b0;
            rresp_nx   = RESP_OKAY;
            arready_nx = 1'b1;
          end else begin
            r_idx_nx  = step_idx(r_idx_r, r_fixed_r);
            rd_addr_s = step_idx(r_idx_r, r_fixed_r);
            rd_load_s = 1'b1;
            r_cnt_nx  = r_cnt_r + 8'd1;
            rlast_nx  = ((r_cnt_r + 8'd1) == r_len_r);
          end
        end else begin
          rd_load_s = 1'b0;
        end
      end
      default: begin
        r_state_nx = R_IDLE;
      end
    endcase
  end

  // Read channel state and output registers; RAM read is read-first against the write port
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state_r <= R_IDLE;
      r_idx_r   <= {IDX_W{1'b0}};
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      r_fixed_r <= 1'b0;
      r_err_r   <= 1'b0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= 2'b00;
      rdata_r   <= {C_AXI_DATA_WIDTH{1'b0}};
`ifdef AXI_SLAVE_RAM_WAIT_EN
      r_wait_r  <= 8'd0;
`endif
    end else begin
      r_state_r <= r_state_nx;
      r_idx_r   <= r_idx_nx;
      r_len_r   <= r_len_nx;
      r_cnt_r   <= r_cnt_nx;
      r_fixed_r <= r_fixed_nx;
      r_err_r   <= r_err_nx;
      arready_r <= arready_nx;
      rvalid_r  <= rvalid_nx;
      rlast_r   <= rlast_nx;
      rresp_r   <= rresp_nx;
      if (rd_load_s) begin
        rdata_r <= r_err_r ? {C_AXI_DATA_WIDTH{1'b0}} : mem_r[rd_addr_s];
      end else begin
        rdata_r <= rdata_r;
      end
`ifdef AXI_SLAVE_RAM_WAIT_EN
      r_wait_r  <= r_wait_nx;
`endif
    end
  end

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed self-checking bench for axi_slave_ram: reset, byte strobes, bursts, stalls,
// error responses, aliasing, read-first collision and mid-burst reset.
module tb_axi_slave_ram;
`ifdef AXI_SLAVE_RAM_WAIT_EN
  localparam int WR_LAT = 5;
  localparam int RD_LAT = 6;
`else
  localparam int WR_LAT = 1;
  localparam int RD_LAT = 2;
`endif
  localparam int LIM = 200;

  logic        CLK, RST_N;
  logic [27:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  axi_slave_ram dut (
    .CLK(CLK), .RST_N(RST_N),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [31:0] wd [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  int          rc [16];
  int          wr_lat, rd_lat, nr;
  logic [1:0]  bresp_v;
  logic [7:0]  last_vec;
  int          n, t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [27:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt, input logic [3:0] strb, input int wl_idx,
                           output logic [1:0] resp);
    int k;
    int t;
    @(negedge CLK);
    AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bt; AWVALID = 1'b1;
    k = 0;
    while (AWREADY !== 1'b1 && k < LIM) begin @(negedge CLK); k++; end
    check("aw_timeout", 32'(k >= LIM), 32'd0);
    @(negedge CLK);
    AWVALID = 1'b0;
    t = cyc;
    wr_lat = -1;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wd[i]; WSTRB = strb; WLAST = (i == wl_idx); WVALID = 1'b1;
      k = 0;
      while (WREADY !== 1'b1 && k < LIM) begin @(negedge CLK); k++; end
      if (i == 0) wr_lat = cyc + 1 - t;
      @(negedge CLK);
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    k = 0;
    while (BVALID !== 1'b1 && k < LIM) begin @(negedge CLK); k++; end
    check("b_timeout", 32'(k >= LIM), 32'd0);
    resp = BRESP;
    @(negedge CLK);
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [27:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input bit toggle);
    int k;
    int t;
    int p;
    bit stalled;
    logic [31:0] held;
    @(negedge CLK);
    ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bt; ARVALID = 1'b1; RREADY = 1'b0;
    k = 0;
    while (ARREADY !== 1'b1 && k < LIM) begin @(negedge CLK); k++; end
    check("ar_timeout", 32'(k >= LIM), 32'd0);
    @(negedge CLK);
    ARVALID = 1'b0;
    t = cyc; rd_lat = -1; nr = 0; k = 0; p = 0; stalled = 1'b0; held = 32'd0;
    while (nr <= int'(len) && k < LIM) begin
      if (RVALID === 1'b1) begin
        if (rd_lat < 0) rd_lat = cyc + 1 - t;
        RREADY = toggle ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
        if (stalled) check("r_hold_data", RDATA, held);
        if (RREADY) begin
          rd[nr] = RDATA; rr[nr] = RRESP; rl[nr] = RLAST; rc[nr] = cyc; nr++;
        end
        stalled = !RREADY;
        held = RDATA;
        p++;
      end else begin
        RREADY = 1'b0;
      end
      @(negedge CLK);
      k++;
    end
    RREADY = 1'b0;
    check("r_timeout", 32'(k >= LIM), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    AWADDR = 28'd0; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = 28'd0; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b0;

    // reset and idle
    repeat (10) @(negedge CLK);
    check("rst_ctrl", 32'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RRESP}), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("idle_awready", 32'(AWREADY), 32'd1);
    check("idle_arready", 32'(ARREADY), 32'd1);

    // byte-strobe write over a preloaded word
    wd[0] = 32'h11223344;
    axi_write(28'h10, 8'd0, 3'd2, 2'b01, 4'b1111, 0, bresp_v);
    check("preload_bresp", 32'(bresp_v), 32'd0);
    check("wready_latency", 32'(wr_lat), 32'(WR_LAT));
    wd[0] = 32'hDEADBEEF;
    axi_write(28'h10, 8'd0, 3'd2, 2'b01, 4'b0011, 0, bresp_v);
    check("strb_bresp", 32'(bresp_v), 32'd0);
    axi_read(28'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    check("strb_rdata", rd[0], 32'h1122BEEF);
    check("single_rlast", 32'(rl[0]), 32'd1);
    check("rvalid_latency_single", 32'(rd_lat), 32'(RD_LAT));

    // 8-beat INCR write then back-to-back read
    for (int i = 0; i < 8; i++) wd[i] = 32'(i);
    axi_write(28'h100, 8'd7, 3'd2, 2'b01, 4'b1111, 7, bresp_v);
    check("burst_bresp", 32'(bresp_v), 32'd0);
    axi_read(28'h100, 8'd7, 3'd2, 2'b01, 1'b0);
    check("burst_rvalid_latency", 32'(rd_lat), 32'(RD_LAT));
    for (int i = 0; i < 8; i++) check("burst_rdata", rd[i], 32'(i));
    for (int i = 0; i < 8; i++) last_vec[i] = rl[i];
    check("burst_rlast_pos", 32'(last_vec), 32'h80);
    check("burst_rresp", 32'({rr[0], rr[1], rr[2], rr[3], rr[4], rr[5], rr[6], rr[7]}), 32'd0);
    check("burst_no_bubbles", 32'(rc[7] - rc[0]), 32'd7);
    check("arready_after_rlast", 32'(ARREADY), 32'd1);

    // same read with RREADY stalls
    axi_read(28'h100, 8'd7, 3'd2, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++) check("stall_rdata", rd[i], 32'(i));
    check("stall_rlast", 32'(rl[7]), 32'd1);

    // size error on read: SLVERR beats carrying zero data
    axi_read(28'h100, 8'd3, 3'd1, 2'b01, 1'b0);
    check("rsize_beats", 32'(nr), 32'd4);
    for (int i = 0; i < 4; i++) check("rsize_rresp", 32'(rr[i]), 32'h2);
    for (int i = 0; i < 4; i++) check("rsize_rdata", rd[i], 32'd0);
    check("rsize_rlast", 32'(rl[3]), 32'd1);

    // size error on write suppresses the store
    wd[0] = 32'hFFFFFFFF;
    axi_write(28'h100, 8'd0, 3'd1, 2'b01, 4'b1111, 0, bresp_v);
    check("wsize_bresp", 32'(bresp_v), 32'h2);
    axi_read(28'h100, 8'd0, 3'd2, 2'b01, 1'b0);
    check("wsize_suppressed", rd[0], 32'd0);

    // early WLAST: four beats still accepted, SLVERR, data kept
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    axi_write(28'h200, 8'd3, 3'd2, 2'b01, 4'b1111, 1, bresp_v);
    check("early_wlast_bresp", 32'(bresp_v), 32'h2);
    axi_read(28'h200, 8'd3, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) check("early_wlast_data", rd[i], 32'hA0 + 32'(i));

    // missing WLAST on the final beat
    wd[0] = 32'h5; wd[1] = 32'h6;
    axi_write(28'h300, 8'd1, 3'd2, 2'b01, 4'b1111, 9, bresp_v);
    check("missing_wlast_bresp", 32'(bresp_v), 32'h2);

    // address alias: 0x2000 maps to word 0
    wd[0] = 32'hA5A5A5A5;
    axi_write(28'h2000, 8'd0, 3'd2, 2'b01, 4'b1111, 0, bresp_v);
    axi_read(28'h0, 8'd0, 3'd2, 2'b01, 1'b0);
    check("alias_word0", rd[0], 32'hA5A5A5A5);

    // same-cycle read and write of word 0: read-first
    @(negedge CLK);
    AWADDR = 28'h0; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    @(negedge CLK);
    AWVALID = 1'b0;
    n = 0;
    while (WREADY !== 1'b1 && n < LIM) begin @(negedge CLK); n++; end
    check("coll_wready_timeout", 32'(n >= LIM), 32'd0);
    ARADDR = 28'h0; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge CLK);
    ARVALID = 1'b0;
    repeat (RD_LAT - 2) @(negedge CLK);
    WDATA = 32'd1; WSTRB = 4'b1111; WLAST = 1'b1; WVALID = 1'b1;
    @(negedge CLK);
    WVALID = 1'b0; WLAST = 1'b0;
    check("coll_rvalid", 32'(RVALID), 32'd1);
    check("coll_read_old", RDATA, 32'hA5A5A5A5);
    check("coll_bvalid", 32'(BVALID), 32'd1);
    check("coll_bresp", 32'(BRESP), 32'd0);
    RREADY = 1'b1; BREADY = 1'b1;
    @(negedge CLK);
    RREADY = 1'b0; BREADY = 1'b0;
    axi_read(28'h0, 8'd0, 3'd2, 2'b01, 1'b0);
    check("coll_read_new", rd[0], 32'd1);

    // reset during beat 3 of a read burst
    @(negedge CLK);
    ARADDR = 28'h100; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge CLK);
    ARVALID = 1'b0;
    RREADY = 1'b1;
    n = 0;
    while (!(RVALID === 1'b1 && RDATA === 32'd2) && n < LIM) begin @(negedge CLK); n++; end
    check("midrst_beat3_timeout", 32'(n >= LIM), 32'd0);
    RST_N = 1'b0;
    #1;
    check("midrst_rvalid", 32'(RVALID), 32'd0);
    check("midrst_ctrl", 32'({AWREADY, WREADY, BVALID, ARREADY, RLAST, RRESP}), 32'd0);
    RREADY = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("midrst_arready", 32'(ARREADY), 32'd1);
    check("midrst_rvalid_after", 32'(RVALID), 32'd0);
    axi_read(28'h100, 8'd7, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) check("midrst_ram_kept", rd[i], 32'(i));
    axi_read(28'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    check("midrst_word4_kept", rd[0], 32'h1122BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
